// File: rtl/divider_5_pkg.sv
// Shared types and constants for the divider_5 sign-magnitude divider.
// The default widths match the 9x9 multiply path it inverts.
package divider_5_pkg;

  localparam int NUM_MAG_DEF = 16;
  localparam int DEN_MAG_DEF = 8;
  localparam int CNT_W       = 4;

  // Quotient magnitude reported for a zero divisor.
  localparam logic [15:0] SAT_MAG = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step_5.sv
// One combinational radix-2 restoring step: shift in a dividend bit,
// then subtract the divisor if it fits.
module div_step_5 #(
  parameter int DEN_MAG = 8
) (
  input  logic [DEN_MAG-1:0] partial_rem,
  input  logic               next_bit,
  input  logic [DEN_MAG-1:0] den_mag,
  output logic [DEN_MAG-1:0] new_rem,
  output logic               q_bit
);

  logic [DEN_MAG:0] trial;

  assign trial = {partial_rem, next_bit};
  assign q_bit = (trial >= {1'b0, den_mag});
  // When the subtraction happens the difference is below den_mag, so the
  // low bits alone produce it; the top bit of trial is not needed.
  assign new_rem = q_bit ? (trial[DEN_MAG-1:0] - den_mag) : trial[DEN_MAG-1:0];

endmodule

// File: rtl/divider_5.sv
// Sequential sign-magnitude divider: one quotient bit per clock, with a
// start/busy/rdy handshake and divide-by-zero saturation.
module divider_5
  import divider_5_pkg::*;
#(
  parameter int NUM_MAG = NUM_MAG_DEF,
  parameter int DEN_MAG = DEN_MAG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_MAG:0]   dividend,
  input  logic [DEN_MAG:0]   divisor,
  output logic [NUM_MAG:0]   quotient,
  output logic [DEN_MAG:0]   remainder,
  output logic               busy,
  output logic               rdy,
  output logic               div_zero
);

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [NUM_MAG-1:0]   num_reg;
  logic [DEN_MAG-1:0]   den_reg;
  logic [DEN_MAG-1:0]   rem_reg;
  logic                 num_sign_reg;
  logic                 den_sign_reg;
  logic                 dz_reg;
  logic [NUM_MAG:0]     quotient_reg;
  logic [DEN_MAG:0]     remainder_reg;
  logic                 busy_reg;
  logic                 rdy_reg;
  logic                 div_zero_reg;

  logic [DEN_MAG-1:0]   step_rem;
  logic                 step_q;

  div_step_5 #(
    .DEN_MAG(DEN_MAG)
  ) u_step (
    .partial_rem(rem_reg),
    .next_bit   (num_reg[NUM_MAG-1]),
    .den_mag    (den_reg),
    .new_rem    (step_rem),
    .q_bit      (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      num_reg       <= '0;
      den_reg       <= '0;
      rem_reg       <= '0;
      num_sign_reg  <= 1'b0;
      den_sign_reg  <= 1'b0;
      dz_reg        <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      busy_reg      <= 1'b0;
      rdy_reg       <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else begin
      rdy_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_reg      <= dividend[NUM_MAG-1:0];
            num_sign_reg <= dividend[NUM_MAG];
            den_reg      <= divisor[DEN_MAG-1:0];
            den_sign_reg <= divisor[DEN_MAG];
            dz_reg       <= (divisor[DEN_MAG-1:0] == '0);
            cnt_reg      <= CNT_W'(NUM_MAG - 1);
            rem_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          // Dividend bits shift out the top while quotient bits fill the bottom.
          rem_reg <= step_rem;
          num_reg <= {num_reg[NUM_MAG-2:0], step_q};
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          rdy_reg      <= 1'b1;
          busy_reg     <= 1'b0;
          div_zero_reg <= dz_reg;
          state_reg    <= IDLE;
          if (dz_reg) begin
            quotient_reg  <= {1'b0, NUM_MAG'(SAT_MAG)};
            remainder_reg <= '0;
          end else begin
            // Zero magnitudes always carry a positive sign.
            quotient_reg  <= {(num_sign_reg ^ den_sign_reg) && (num_reg != '0), num_reg};
            remainder_reg <= {num_sign_reg && (rem_reg != '0), rem_reg};
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign busy      = busy_reg;
  assign rdy       = rdy_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_divider_5.sv
// Directed self-checking bench for divider_5: arithmetic, signs, divide by
// zero, handshake timing, start-while-busy and asynchronous reset mid-operation.
module tb_divider_5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] dividend;
  logic [8:0]  divisor;
  logic [16:0] quotient;
  logic [8:0]  remainder;
  logic        busy;
  logic        rdy;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  divider_5 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .rdy      (rdy),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation and checks latency, busy and the result.
  task automatic run_op(input logic [16:0] a, input logic [8:0] b,
                        input logic [16:0] eq, input logic [8:0] er,
                        input logic edz, input string tag);
    int early;
    early = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    repeat (16) begin
      @(negedge clk);
      if (rdy) early++;
    end
    chk({tag, "_rdy_early"}, 32'(early), 32'd0);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(rdy), 32'd1);
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dz"}, 32'(div_zero), 32'(edz));
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_rdy_pulse"}, 32'(rdy), 32'd0);
    $display("op %s: %h / %h -> q=%h r=%h dz=%0d", tag, a, b, quotient, remainder, div_zero);
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(quotient), 32'd0);
    chk("reset_r", 32'(remainder), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_dz", 32'(div_zero), 32'd0);
    rst = 1'b0;

    run_op(17'h003E8, 9'h007, 17'h0008E, 9'h006, 1'b0, "p1000_p7");
    run_op(17'h10064, 9'h00A, 17'h1000A, 9'h000, 1'b0, "m100_p10");
    run_op(17'h103E8, 9'h007, 17'h1008E, 9'h106, 1'b0, "m1000_p7");
    run_op(17'h003E8, 9'h107, 17'h1008E, 9'h006, 1'b0, "p1000_m7");
    run_op(17'h0FFFF, 9'h001, 17'h0FFFF, 9'h000, 1'b0, "max_div1");
    run_op(17'h0FFFF, 9'h0FF, 17'h00101, 9'h000, 1'b0, "max_divff");
    run_op(17'h10000, 9'h005, 17'h00000, 9'h000, 1'b0, "mzero_p5");
    run_op(17'h01234, 9'h100, 17'h0FFFF, 9'h000, 1'b1, "div_zero");
    run_op(17'h00032, 9'h003, 17'h00010, 9'h002, 1'b0, "dz_clear");

    // start held high; operands change mid-CALC and must not disturb op A.
    @(negedge clk);
    dividend = 17'h003E8;
    divisor  = 9'h007;
    start    = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    dividend = 17'h00032;
    divisor  = 9'h003;
    cnt = 0;
    repeat (13) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    chk("hold_rdy_early", 32'(cnt), 32'd0);
    @(negedge clk);
    chk("hold_a_rdy", 32'(rdy), 32'd1);
    chk("hold_a_q", 32'(quotient), 32'h0008E);
    chk("hold_a_r", 32'(remainder), 32'h006);
    $display("op hold_a: q=%h r=%h", quotient, remainder);
    cnt = 0;
    repeat (17) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    chk("hold_gap_rdy", 32'(cnt), 32'd0);
    @(negedge clk);
    chk("hold_b_rdy", 32'(rdy), 32'd1);
    chk("hold_b_q", 32'(quotient), 32'h00010);
    chk("hold_b_r", 32'(remainder), 32'h002);
    $display("op hold_b: q=%h r=%h", quotient, remainder);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Put nonzero results on the outputs, then reset five cycles into CALC.
    run_op(17'h003E8, 9'h007, 17'h0008E, 9'h006, 1'b0, "pre_rst");
    @(negedge clk);
    dividend = 17'h0FFFF;
    divisor  = 9'h001;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_q", 32'(quotient), 32'd0);
    chk("midrst_r", 32'(remainder), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdy", 32'(rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy || busy) cnt++;
    end
    chk("midrst_quiet", 32'(cnt), 32'd0);
    $display("op mid_reset: outputs cleared, no rdy");
    run_op(17'h00032, 9'h003, 17'h00010, 9'h002, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
